regfile_writeback: RTL and testbench

- Writer side of the integer register file's single write port (wa3/wd3/we3).
- Arbitrates two result producers onto that one port:
  - Port A: single-cycle ALU results.
  - Port B: long-latency LSU/MUL results.
- Holds a pending-destination scoreboard so issue logic can stall on registers still awaiting writeback.
- Sits between the execute stages and the register file.

---
 rtl/regfile_wb_pkg.sv | 24 ++
 rtl/wb_scoreboard.sv | 43 ++++
 rtl/regfile_writeback.sv | 126 ++++++++++++
 tb/tb_regfile_writeback.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_wb_pkg.sv
// ============================================================================
// regfile_wb_pkg : shared constants, request type and counter sizing for the
//                  register-file writeback block.  Rev 1.0
// ============================================================================
`default_nettype none

package regfile_wb_pkg;

  localparam int unsigned c_bank_width = 5;
  localparam int unsigned c_width      = 64;

  typedef struct packed {
    logic [c_bank_width-1:0] addr;
    logic [c_width-1:0]      data;
  } wb_req_t;

  // Counter must be able to hold the value STARVE_LIMIT itself.
  function automatic int unsigned starve_cnt_width(input int unsigned limit);
    return (limit < 1) ? 1 : $clog2(limit + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/wb_scoreboard.sv
// ============================================================================
// wb_scoreboard : per-register pending-write bits; set on issue, cleared on
//                 register-file commit, set wins on collision.  Rev 1.0
// ============================================================================
`default_nettype none

module wb_scoreboard #(
  parameter int unsigned BANK_WIDTH = 5
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       set_en,
  input  logic [BANK_WIDTH-1:0]      set_addr,
  input  logic                       clr_en,
  input  logic [BANK_WIDTH-1:0]      clr_addr,
  output logic [2**BANK_WIDTH-1:0]   busy
);

  localparam int unsigned c_nreg = 2**BANK_WIDTH;

  logic [c_nreg-1:1] w_set;
  logic [c_nreg-1:1] w_clr;
  logic [c_nreg-1:1] r_busy;

  // x0 is never tracked, so decode starts at register 1.
  for (genvar i = 1; i < c_nreg; i++) begin : g_decode
    assign w_set[i] = set_en && (set_addr == BANK_WIDTH'(i));
    assign w_clr[i] = clr_en && (clr_addr == BANK_WIDTH'(i));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy <= '0;
    end else begin
      r_busy <= (r_busy & ~w_clr) | w_set;
    end
  end

  assign busy = {r_busy, 1'b0};

endmodule

`default_nettype wire

// File: rtl/regfile_writeback.sv
// ============================================================================
// regfile_writeback : arbitrates ALU (A) and LSU/MUL (B) results onto the
//                     single register-file write port, with starvation guard
//                     and pending-destination scoreboard.
//                     Optional forwarding ports: REGFILE_WB_BYPASS_EN.
//                     Rev 1.0
// ============================================================================
`default_nettype none

module regfile_writeback
  import regfile_wb_pkg::*;
#(
  parameter int unsigned BANK_WIDTH   = c_bank_width,
  parameter int unsigned WIDTH        = c_width,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     a_valid,
  input  logic [BANK_WIDTH-1:0]    a_addr,
  input  logic [WIDTH-1:0]         a_data,
  output logic                     a_ready,
  input  logic                     b_valid,
  input  logic [BANK_WIDTH-1:0]    b_addr,
  input  logic [WIDTH-1:0]         b_data,
  output logic                     b_ready,
  input  logic                     iss_valid,
  input  logic [BANK_WIDTH-1:0]    iss_rd,
  output logic [BANK_WIDTH-1:0]    wa3,
  output logic [WIDTH-1:0]         wd3,
  output logic                     we3,
  output logic [2**BANK_WIDTH-1:0] busy
`ifdef REGFILE_WB_BYPASS_EN
  ,
  input  logic [BANK_WIDTH-1:0]    ra1,
  input  logic [BANK_WIDTH-1:0]    ra2,
  output logic                     fwd1_hit,
  output logic                     fwd2_hit,
  output logic [WIDTH-1:0]         fwd1_data,
  output logic [WIDTH-1:0]         fwd2_data
`endif
);

  localparam int unsigned    c_cnt_w = starve_cnt_width(STARVE_LIMIT);
  localparam logic [c_cnt_w-1:0] c_limit = c_cnt_w'(STARVE_LIMIT);

  logic [c_cnt_w-1:0]    r_starve_cnt;
  logic                  w_b_prio;
  logic                  w_a_xfer;
  logic                  w_b_xfer;
  logic                  w_xfer;
  logic [BANK_WIDTH-1:0] w_req_addr;
  logic [WIDTH-1:0]      w_req_data;
  logic                  r_we3;
  logic [BANK_WIDTH-1:0] r_wa3;
  logic [WIDTH-1:0]      r_wd3;

  assign w_b_prio = (r_starve_cnt == c_limit);

  // Each ready looks only at the other port's valid, never its own.
  always_comb begin
    a_ready = 1'b1;
    b_ready = !a_valid;
    if (w_b_prio) begin
      a_ready = !b_valid;
      b_ready = 1'b1;
    end
  end

  assign w_a_xfer   = a_valid && a_ready;
  assign w_b_xfer   = b_valid && b_ready;
  assign w_xfer     = w_a_xfer || w_b_xfer;
  assign w_req_addr = w_b_xfer ? b_addr : a_addr;
  assign w_req_data = w_b_xfer ? b_data : a_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_starve_cnt <= '0;
    end else if (!b_valid || w_b_xfer) begin
      r_starve_cnt <= '0;
    end else if (r_starve_cnt != c_limit) begin
      r_starve_cnt <= r_starve_cnt + 1'b1;
    end
  end

  // Writes to x0 are accepted but never reach the register file.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_we3 <= 1'b0;
      r_wa3 <= '0;
      r_wd3 <= '0;
    end else begin
      r_we3 <= w_xfer && (w_req_addr != '0);
      if (w_xfer) begin
        r_wa3 <= w_req_addr;
        r_wd3 <= w_req_data;
      end
    end
  end

  assign we3 = r_we3;
  assign wa3 = r_wa3;
  assign wd3 = r_wd3;

  wb_scoreboard #(
    .BANK_WIDTH (BANK_WIDTH)
  ) u_scoreboard (
    .clk      (clk),
    .rst_n    (rst_n),
    .set_en   (iss_valid),
    .set_addr (iss_rd),
    .clr_en   (r_we3),
    .clr_addr (r_wa3),
    .busy     (busy)
  );

`ifdef REGFILE_WB_BYPASS_EN
  assign fwd1_hit  = r_we3 && (r_wa3 != '0) && (r_wa3 == ra1);
  assign fwd2_hit  = r_we3 && (r_wa3 != '0) && (r_wa3 == ra2);
  assign fwd1_data = fwd1_hit ? r_wd3 : '0;
  assign fwd2_data = fwd2_hit ? r_wd3 : '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_regfile_writeback.sv
// ============================================================================
// tb_regfile_writeback : scoreboard bench for regfile_writeback.  Rev 1.0
// ============================================================================
`default_nettype none

module tb_regfile_writeback;
  import regfile_wb_pkg::*;

  localparam int unsigned c_limit = 4;

  logic        clk;
  logic        rst_n;
  logic        a_valid;
  logic [4:0]  a_addr;
  logic [63:0] a_data;
  logic        a_ready;
  logic        b_valid;
  logic [4:0]  b_addr;
  logic [63:0] b_data;
  logic        b_ready;
  logic        iss_valid;
  logic [4:0]  iss_rd;
  logic [4:0]  wa3;
  logic [63:0] wd3;
  logic        we3;
  logic [31:0] busy;
`ifdef REGFILE_WB_BYPASS_EN
  logic [4:0]  ra1;
  logic [4:0]  ra2;
  logic        fwd1_hit;
  logic        fwd2_hit;
  logic [63:0] fwd1_data;
  logic [63:0] fwd2_data;
`endif

  int checks = 0;
  int errors = 0;

  regfile_writeback #(
    .BANK_WIDTH   (5),
    .WIDTH        (64),
    .STARVE_LIMIT (c_limit)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .a_valid   (a_valid),
    .a_addr    (a_addr),
    .a_data    (a_data),
    .a_ready   (a_ready),
    .b_valid   (b_valid),
    .b_addr    (b_addr),
    .b_data    (b_data),
    .b_ready   (b_ready),
    .iss_valid (iss_valid),
    .iss_rd    (iss_rd),
    .wa3       (wa3),
    .wd3       (wd3),
    .we3       (we3),
    .busy      (busy)
`ifdef REGFILE_WB_BYPASS_EN
    ,
    .ra1       (ra1),
    .ra2       (ra2),
    .fwd1_hit  (fwd1_hit),
    .fwd2_hit  (fwd2_hit),
    .fwd1_data (fwd1_data),
    .fwd2_data (fwd2_data)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model, advanced on every falling edge while enabled.
  wb_req_t     exp_q[$];
  wb_req_t     m_head;
  logic        m_had;
  logic [31:0] m_busy;
  int          m_cnt;
  logic        m_a_rdy;
  logic        m_b_rdy;
  logic        mon_en;

  task automatic model_reset();
    exp_q.delete();
    m_busy = '0;
    m_cnt  = 0;
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      m_had = (exp_q.size() != 0);
      if (m_had) begin
        m_head = exp_q.pop_front();
        check_eq("we3", {63'd0, we3}, 64'd1);
        check_eq("wa3", {59'd0, wa3}, {59'd0, m_head.addr});
        check_eq("wd3", wd3, m_head.data);
      end else begin
        check_eq("we3_idle", {63'd0, we3}, 64'd0);
      end
      check_eq("busy", {32'd0, busy}, {32'd0, m_busy});
      m_a_rdy = (m_cnt == c_limit) ? !b_valid : 1'b1;
      m_b_rdy = (m_cnt == c_limit) ? 1'b1 : !a_valid;
      check_eq("a_ready", {63'd0, a_ready}, {63'd0, m_a_rdy});
      check_eq("b_ready", {63'd0, b_ready}, {63'd0, m_b_rdy});
      if (m_had) m_busy[m_head.addr] = 1'b0;
      if (iss_valid && iss_rd != 5'd0) m_busy[iss_rd] = 1'b1;
      if (a_valid && m_a_rdy) begin
        if (a_addr != 5'd0) exp_q.push_back('{addr: a_addr, data: a_data});
      end else if (b_valid && m_b_rdy) begin
        if (b_addr != 5'd0) exp_q.push_back('{addr: b_addr, data: b_data});
      end
      if (!b_valid || m_b_rdy) m_cnt = 0;
      else if (m_cnt != c_limit) m_cnt = m_cnt + 1;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic a_took;
  logic b_took;

  initial begin
    mon_en    = 1'b0;
    rst_n     = 1'b0;
    a_valid   = 1'b0; a_addr = '0; a_data = '0;
    b_valid   = 1'b0; b_addr = '0; b_data = '0;
    iss_valid = 1'b0; iss_rd = '0;
`ifdef REGFILE_WB_BYPASS_EN
    ra1 = '0; ra2 = '0;
`endif
    model_reset();
    step();
    step();
    check_eq("rst_we3", {63'd0, we3}, 64'd0);
    check_eq("rst_wa3", {59'd0, wa3}, 64'd0);
    check_eq("rst_wd3", wd3, 64'd0);
    check_eq("rst_busy", {32'd0, busy}, 64'd0);
    rst_n  = 1'b1;
    mon_en = 1'b1;
    step();

    // Single A write
    a_valid = 1'b1; a_addr = 5'd5; a_data = 64'hAA;
    step();
    a_valid = 1'b0;
    check_eq("single_we3", {63'd0, we3}, 64'd1);
    check_eq("single_wa3", {59'd0, wa3}, 64'd5);
    check_eq("single_wd3", wd3, 64'hAA);
    step();
    check_eq("single_we3_off", {63'd0, we3}, 64'd0);

    // Contention: A wins STARVE_LIMIT grants, then B gets one
    a_valid = 1'b1; a_addr = 5'd1; a_data = 64'h11;
    b_valid = 1'b1; b_addr = 5'd7; b_data = 64'h77;
    for (int i = 0; i < c_limit; i++) begin
      #1;
      check_eq("cont_a_ready", {63'd0, a_ready}, 64'd1);
      check_eq("cont_b_ready", {63'd0, b_ready}, 64'd0);
      step();
    end
    check_eq("starve_b_ready", {63'd0, b_ready}, 64'd1);
    check_eq("starve_a_ready", {63'd0, a_ready}, 64'd0);
    step();
    a_valid = 1'b0; b_valid = 1'b0;
    check_eq("starve_we3", {63'd0, we3}, 64'd1);
    check_eq("starve_wa3", {59'd0, wa3}, 64'd7);
    check_eq("starve_cnt", {61'd0, dut.r_starve_cnt}, 64'd0);
    step();

    // x0 write is accepted but dropped
    a_valid = 1'b1; a_addr = 5'd0; a_data = 64'hFF;
    #1;
    check_eq("x0_a_ready", {63'd0, a_ready}, 64'd1);
    step();
    a_valid = 1'b0;
    check_eq("x0_we3", {63'd0, we3}, 64'd0);
    check_eq("x0_busy0", {63'd0, busy[0]}, 64'd0);
    step();

    // Scoreboard set, clear, and set-wins collision
    iss_valid = 1'b1; iss_rd = 5'd9;
    step();
    iss_valid = 1'b0;
    check_eq("sb_set", {63'd0, busy[9]}, 64'd1);
    b_valid = 1'b1; b_addr = 5'd9; b_data = 64'h99;
    step();
    b_valid = 1'b0;
    check_eq("sb_hold_until_commit", {63'd0, busy[9]}, 64'd1);
    step();
    check_eq("sb_clear", {63'd0, busy[9]}, 64'd0);
    iss_valid = 1'b1; iss_rd = 5'd9;
    step();
    iss_valid = 1'b0;
    b_valid = 1'b1; b_addr = 5'd9; b_data = 64'h999;
    step();
    b_valid = 1'b0;
    iss_valid = 1'b1; iss_rd = 5'd9;
    step();
    iss_valid = 1'b0;
    check_eq("sb_set_wins", {63'd0, busy[9]}, 64'd1);
    a_valid = 1'b1; a_addr = 5'd9; a_data = 64'h9A;
    step();
    a_valid = 1'b0;
    step();
    check_eq("sb_final_clear", {63'd0, busy[9]}, 64'd0);

`ifdef REGFILE_WB_BYPASS_EN
    ra1 = 5'd3; ra2 = 5'd4;
    a_valid = 1'b1; a_addr = 5'd3; a_data = 64'h1234;
    step();
    a_valid = 1'b0;
    check_eq("fwd1_hit", {63'd0, fwd1_hit}, 64'd1);
    check_eq("fwd1_data", fwd1_data, 64'h1234);
    check_eq("fwd2_hit", {63'd0, fwd2_hit}, 64'd0);
    check_eq("fwd2_data", fwd2_data, 64'd0);
    step();
`endif

    // Random traffic honouring the hold-while-stalled rule
    a_took = 1'b1;
    b_took = 1'b1;
    for (int n = 0; n < 400; n++) begin
      if (!a_valid || a_took) begin
        a_valid = 1'($urandom_range(0, 1));
        a_addr  = 5'($urandom);
        a_data  = {$urandom, $urandom};
      end
      if (!b_valid || b_took) begin
        b_valid = ($urandom_range(0, 3) != 0);
        b_addr  = 5'($urandom);
        b_data  = {$urandom, $urandom};
      end
      iss_valid = ($urandom_range(0, 2) == 0);
      iss_rd    = 5'($urandom);
      #1;
      a_took = a_valid && a_ready;
      b_took = b_valid && b_ready;
      step();
    end
    a_valid = 1'b0; b_valid = 1'b0; iss_valid = 1'b0;
    step();

    // Asynchronous reset with a write in flight and busy bits set
    iss_valid = 1'b1; iss_rd = 5'd8;
    step();
    iss_rd = 5'd9;
    step();
    iss_valid = 1'b0;
    step();
    step();
    a_valid = 1'b1; a_addr = 5'd5; a_data = 64'h55;
    b_valid = 1'b1; b_addr = 5'd2; b_data = 64'h22;
    step();
    a_valid = 1'b0; b_valid = 1'b0;
    check_eq("pre_rst_we3", {63'd0, we3}, 64'd1);
    check_eq("pre_rst_busy", {32'd0, busy & 32'h0000_0300}, 64'h300);
    check_eq("pre_rst_cnt", {61'd0, dut.r_starve_cnt}, 64'd1);
    mon_en = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    check_eq("arst_we3", {63'd0, we3}, 64'd0);
    check_eq("arst_busy", {32'd0, busy}, 64'd0);
    check_eq("arst_cnt", {61'd0, dut.r_starve_cnt}, 64'd0);
    check_eq("arst_wa3", {59'd0, wa3}, 64'd0);
    step();
    rst_n = 1'b1;
    model_reset();
    mon_en = 1'b1;
    a_valid = 1'b1; a_addr = 5'd12; a_data = 64'hC0FFEE;
    step();
    a_valid = 1'b0;
    check_eq("post_rst_wa3", {59'd0, wa3}, 64'd12);
    step();
    step();

    mon_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
